rr_request_mux: RTL and testbench
=================================

Name: rr_request_mux

Overview:
- Parametrised successor to the combinational request mux.
- Arbitrates among NCONSUMERS valid/ready request channels using round-robin or fixed priority.
- Supports multi-beat burst locking and per-channel enables.
- Forwards the winner through a registered output stage with a valid/ready handshake. Sits between consumer request ports and the shared memory/service port.

Parameters:
- NCONSUMERS, 8: number of request channels (>=1).
- REQ_WIDTH, 32: request payload width.
- ARB_MODE, ARB_RR: ARB_RR = round-robin; ARB_FIXED = lowest index wins.
- LOCK_EN, 1: 1 = hold grant until the beat with req_last is transferred; 0 = re-arbitrate every beat.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- chan_en  in  NCONSUMERS  per-channel arbitration enable.
- req_valid  in  NCONSUMERS  request valid per channel.
- req_last  in  NCONSUMERS  final beat of burst per channel.
- req_data  in  REQ_WIDTH x NCONSUMERS (unpacked array)  request payload.
- req_ready  out  NCONSUMERS  accept per channel.
- out_valid  out  1  registered output valid.
- out_data  out  REQ_WIDTH  registered payload.
- out_src  out  SRC_W  index of the channel that produced out_data; SRC_W = max(1, $clog2(NCONSUMERS)).
- out_last  out  1  registered copy of req_last.
- out_ready  in  1  downstream accept.

Behaviour:
- Reset (rst low, async):
  - out_valid=0, out_data=0, out_src=0, out_last=0.
  - Round-robin pointer ptr=0, state=ARB.
  - req_ready forced to 0 while rst is low.
- Transfer definitions:
  - Upstream transfer on channel i: req_valid[i] & req_ready[i] at posedge clk.
  - Downstream transfer: out_valid & out_ready.
- load = !out_valid | out_ready (combinational). Gives full throughput: one beat per cycle when out_ready is held high.
- State ARB:
  - Eligible set = req_valid & chan_en.
  - ARB_RR winner: first eligible index scanning ptr, ptr+1, ..., wrapping modulo NCONSUMERS.
  - ARB_FIXED winner: lowest eligible index.
  - req_ready[w] = load; all other req_ready = 0. If nothing is eligible, all req_ready = 0.
  - On transfer: out_data<=req_data[w], out_src<=w, out_last<=req_last[w], out_valid<=1.
  - If LOCK_EN and !req_last[w]: go to LOCKED, lock_idx<=w.
  - Otherwise ptr<=(w+1) mod NCONSUMERS (round-robin only).
- State LOCKED:
  - req_ready[lock_idx] = load, independent of chan_en. Other channels get ready=0.
  - Idle cycles (req_valid[lock_idx]=0) keep the lock.
  - Transfer with req_last=1: go to ARB, ptr<=(lock_idx+1) mod NCONSUMERS.
- Output stage:
  - When load and no upstream transfer, out_valid<=0.
  - While out_valid & !out_ready, out_data/out_src/out_last are held stable.
- Latency: exactly 1 cycle from an upstream transfer to out_valid.
- Boundary cases:
  - NCONSUMERS=1: ptr stays 0, out_src=0.
  - ptr wrap: after a grant to NCONSUMERS-1, ptr returns to 0.
  - chan_en dropped mid-burst: lock persists.
  - A channel whose valid rises in the same cycle as a grant elsewhere waits for the next arbitration.
  - Reset mid-burst: lock and pending output are discarded.
- Assertions:
  - req_ready is one-hot or zero.
  - out_data stable under backpressure.

Decomposition:
- Package request_mux_pkg: arb_mode_e {ARB_RR, ARB_FIXED}, state_e {ARB, LOCKED}, SRC_W helper function.
- Sub-module rr_priority_pick: combinational pick.
  - Inputs: eligible vector, ptr, mode.
  - Outputs: winner index, any_valid.
  - Implemented as a double-width rotate-and-priority-encode.

Test Plan (NCONSUMERS=8, REQ_WIDTH=32, data[i]=1000*i, single-beat requests with req_last=1 unless stated):
- Single channel: req_valid=0x08, out_ready=1 -> 1 cycle later out_valid=1, out_data=3000, out_src=3; req_ready=0x08 in the accept cycle.
- Round-robin fairness: req_valid=0xFF held, out_ready=1 -> out_src sequence 0,1,2,...,7,0 on consecutive cycles; data 0,1000,...,7000,0.
- Fixed priority: ARB_FIXED, req_valid=0xA4 held -> out_src stays 2, out_data=2000 every cycle.
- Backpressure: out_ready=0 for 5 cycles with channels 5 and 6 valid -> out_data=5000, out_src=5 held stable and req_ready=0; out_ready=1 -> out_src=6 next cycle.
- Burst lock: channel 1 sends 3 beats (last on beat 3) while channel 4 is valid -> out_src=1,1,1 then 4; ptr=2 after the burst.
- Async reset mid-burst: rst low during LOCKED with out_valid=1 -> out_valid=0 immediately; after release, req_valid=0x10 -> out_src=4.

Source files
------------

// File: rtl/rr_request_mux_pkg.sv
// Shared types and helpers for the round-robin request mux and its arbiter.
package request_mux_pkg;

   typedef enum logic {
      ARB_RR    = 1'b0,
      ARB_FIXED = 1'b1
   } arb_mode_e;

   typedef enum logic {
      ARB    = 1'b0,
      LOCKED = 1'b1
   } state_e;

   // Source index width; a single-channel mux still carries a 1-bit out_src.
   function automatic int src_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_request_mux_if.sv
// Request-side and output-side handshake bundle of the request mux.
interface rr_request_mux_if #(
   parameter int NCONSUMERS = 8,
   parameter int REQ_WIDTH  = 32
);
   import request_mux_pkg::*;

   localparam int SRC_W = src_w(NCONSUMERS);

   logic [NCONSUMERS-1:0] chan_en;
   logic [NCONSUMERS-1:0] req_valid;
   logic [NCONSUMERS-1:0] req_last;
   logic [REQ_WIDTH-1:0]  req_data [NCONSUMERS];
   logic [NCONSUMERS-1:0] req_ready;
   logic                  out_valid;
   logic [REQ_WIDTH-1:0]  out_data;
   logic [SRC_W-1:0]      out_src;
   logic                  out_last;
   logic                  out_ready;

   modport master (
      output chan_en, req_valid, req_last, req_data, out_ready,
      input  req_ready, out_valid, out_data, out_src, out_last
   );

   modport slave (
      input  chan_en, req_valid, req_last, req_data, out_ready,
      output req_ready, out_valid, out_data, out_src, out_last
   );

endinterface

// File: rtl/rr_request_mux_pick.sv
// Combinational winner pick: rotate the eligible vector to start at ptr, then
// take the lowest set bit and map it back to an absolute channel index.
module rr_priority_pick
   import request_mux_pkg::*;
#(
   parameter int NCONSUMERS = 8,
   parameter int SRC_W      = src_w(NCONSUMERS)
) (
   input  logic [NCONSUMERS-1:0] eligible_i,
   input  logic [SRC_W-1:0]      ptr_i,
   input  arb_mode_e             mode_i,
   output logic [SRC_W-1:0]      winner_o,
   output logic                  any_valid_o
);

   logic [SRC_W-1:0]      start;
   logic [NCONSUMERS-1:0] rot;
   logic [SRC_W-1:0]      k;
   logic [SRC_W:0]        sum;

   assign start       = (mode_i == ARB_FIXED) ? '0 : ptr_i;
   assign rot         = NCONSUMERS'({eligible_i, eligible_i} >> start);
   assign any_valid_o = |eligible_i;

   always_comb begin
      k = '0;
      for (int i = NCONSUMERS - 1; i >= 0; i--) begin
         if (rot[i]) begin
            k = SRC_W'(i);
         end
      end
   end

   assign sum      = {1'b0, start} + {1'b0, k};
   assign winner_o = (sum >= (SRC_W + 1)'(NCONSUMERS)) ?
                     SRC_W'(sum - (SRC_W + 1)'(NCONSUMERS)) : sum[SRC_W-1:0];

endmodule

// File: rtl/rr_request_mux.sv
// Round-robin / fixed-priority request mux with burst locking and a registered
// valid/ready output stage feeding the shared service port.
module rr_request_mux
   import request_mux_pkg::*;
#(
   parameter int        NCONSUMERS = 8,
   parameter int        REQ_WIDTH  = 32,
   parameter arb_mode_e ARB_MODE   = ARB_RR,
   parameter bit        LOCK_EN    = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   rr_request_mux_if.slave bus
);

   localparam int SRC_W = src_w(NCONSUMERS);

   state_e                state_q, state_d;
   logic [SRC_W-1:0]      ptr_q, ptr_d;
   logic [SRC_W-1:0]      lock_idx_q, lock_idx_d;
   logic                  out_valid_q;
   logic                  out_last_q;
   logic [REQ_WIDTH-1:0]  out_data_q;
   logic [SRC_W-1:0]      out_src_q;

   logic [NCONSUMERS-1:0] eligible;
   logic [NCONSUMERS-1:0] ready_vec;
   logic [SRC_W-1:0]      winner;
   logic [SRC_W-1:0]      sel;
   logic                  any_valid;
   logic                  load;
   logic                  xfer;

   function automatic logic [SRC_W-1:0] next_idx(input logic [SRC_W-1:0] idx);
      return (idx == SRC_W'(NCONSUMERS - 1)) ? '0 : idx + 1'b1;
   endfunction

   assign eligible = bus.req_valid & bus.chan_en;
   assign load     = !out_valid_q || bus.out_ready;

   rr_priority_pick #(
      .NCONSUMERS (NCONSUMERS),
      .SRC_W      (SRC_W)
   ) u_pick (
      .eligible_i  (eligible),
      .ptr_i       (ptr_q),
      .mode_i      (ARB_MODE),
      .winner_o    (winner),
      .any_valid_o (any_valid)
   );

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      lock_idx_d = lock_idx_q;
      ready_vec  = '0;
      sel        = winner;
      xfer       = 1'b0;
      case (state_q)
         ARB: begin
            if (any_valid) begin
               ready_vec[winner] = load;
               xfer              = load;
            end
            if (xfer) begin
               if (LOCK_EN && !bus.req_last[winner]) begin
                  state_d    = LOCKED;
                  lock_idx_d = winner;
               end else if (ARB_MODE == ARB_RR) begin
                  ptr_d = next_idx(winner);
               end
            end
         end
         LOCKED: begin
            // The lock owner keeps the port even if its chan_en drops.
            sel                   = lock_idx_q;
            ready_vec[lock_idx_q] = load;
            xfer                  = load && bus.req_valid[lock_idx_q];
            if (xfer && bus.req_last[lock_idx_q]) begin
               state_d = ARB;
               if (ARB_MODE == ARB_RR) begin
                  ptr_d = next_idx(lock_idx_q);
               end
            end
         end
         default: state_d = ARB;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ARB;
         ptr_q       <= '0;
         lock_idx_q  <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_src_q   <= '0;
         out_last_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         lock_idx_q <= lock_idx_d;
         if (load) begin
            out_valid_q <= xfer;
         end
         if (xfer) begin
            out_data_q <= bus.req_data[sel];
            out_src_q  <= sel;
            out_last_q <= bus.req_last[sel];
         end
      end
   end

   assign bus.req_ready = rst ? ready_vec : '0;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_src   = out_src_q;
   assign bus.out_last  = out_last_q;

   a_ready_onehot : assert property (@(posedge clk) disable iff (!rst)
      $onehot0(bus.req_ready));

   a_hold_stable : assert property (@(posedge clk) disable iff (!rst)
      (out_valid_q && !bus.out_ready) |=>
         ($stable(out_data_q) && $stable(out_src_q) && $stable(out_last_q)));

endmodule

// File: tb/tb_rr_request_mux.sv
// Bench for rr_request_mux: a round-robin locking instance and a fixed-priority
// non-locking instance share stimulus and are tracked by a behavioural model.
module tb_rr_request_mux;
   import request_mux_pkg::*;

   localparam int N = 8;
   localparam int W = 32;

   logic         clk       = 1'b0;
   logic         rst       = 1'b0;
   logic [N-1:0] chan_en   = '1;
   logic [N-1:0] req_valid = '0;
   logic [N-1:0] req_last  = '1;
   logic [W-1:0] req_data [N];
   logic         out_ready = 1'b1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rr_request_mux_if #(.NCONSUMERS(N), .REQ_WIDTH(W)) bif0 ();
   rr_request_mux_if #(.NCONSUMERS(N), .REQ_WIDTH(W)) bif1 ();

   assign bif0.chan_en   = chan_en;
   assign bif0.req_valid = req_valid;
   assign bif0.req_last  = req_last;
   assign bif0.req_data  = req_data;
   assign bif0.out_ready = out_ready;
   assign bif1.chan_en   = chan_en;
   assign bif1.req_valid = req_valid;
   assign bif1.req_last  = req_last;
   assign bif1.req_data  = req_data;
   assign bif1.out_ready = out_ready;

   rr_request_mux #(.NCONSUMERS(N), .REQ_WIDTH(W), .ARB_MODE(ARB_RR), .LOCK_EN(1'b1))
      dut_rr (.clk(clk), .rst(rst), .bus(bif0));

   rr_request_mux #(.NCONSUMERS(N), .REQ_WIDTH(W), .ARB_MODE(ARB_FIXED), .LOCK_EN(1'b0))
      dut_fx (.clk(clk), .rst(rst), .bus(bif1));

   // Model state per instance: 0 = round-robin with lock, 1 = fixed, no lock.
   int           m_ptr    [2] = '{0, 0};
   bit           m_locked [2] = '{0, 0};
   int           m_lock   [2] = '{0, 0};
   bit           m_valid  [2] = '{0, 0};
   logic [W-1:0] m_data   [2] = '{0, 0};
   int           m_src    [2] = '{0, 0};
   bit           m_last   [2] = '{0, 0};

   function automatic int pick(input logic [N-1:0] elig, input int ptr, input bit fixed);
      int start = fixed ? 0 : ptr;
      for (int j = 0; j < N; j++) begin
         if (elig[(start + j) % N]) return (start + j) % N;
      end
      return -1;
   endfunction

   function automatic logic [N-1:0] exp_ready(input int d);
      logic [N-1:0] r = '0;
      bit load = !m_valid[d] || out_ready;
      int w;
      if (!rst) return '0;
      if (m_locked[d]) begin
         r[m_lock[d]] = load;
      end else begin
         w = pick(req_valid & chan_en, m_ptr[d], d == 1);
         if (w >= 0) r[w] = load;
      end
      return r;
   endfunction

   function automatic int xfer_ch(input int d);
      logic [N-1:0] r = exp_ready(d) & req_valid;
      for (int i = 0; i < N; i++) begin
         if (r[i]) return i;
      end
      return -1;
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int d = 0; d < 2; d++) begin
            m_ptr[d]    <= 0;
            m_locked[d] <= 1'b0;
            m_lock[d]   <= 0;
            m_valid[d]  <= 1'b0;
            m_data[d]   <= '0;
            m_src[d]    <= 0;
            m_last[d]   <= 1'b0;
         end
      end else begin
         for (int d = 0; d < 2; d++) begin
            if (!m_valid[d] || out_ready) m_valid[d] <= (xfer_ch(d) >= 0);
            if (xfer_ch(d) >= 0) begin
               m_data[d] <= req_data[xfer_ch(d)];
               m_src[d]  <= xfer_ch(d);
               m_last[d] <= req_last[xfer_ch(d)];
               if (m_locked[d]) begin
                  if (req_last[xfer_ch(d)]) begin
                     m_locked[d] <= 1'b0;
                     if (d == 0) m_ptr[d] <= (xfer_ch(d) + 1) % N;
                  end
               end else if (d == 0 && !req_last[xfer_ch(d)]) begin
                  m_locked[d] <= 1'b1;
                  m_lock[d]   <= xfer_ch(d);
               end else if (d == 0) begin
                  m_ptr[d] <= (xfer_ch(d) + 1) % N;
               end
            end
         end
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cmp_dut(input int d, input logic [N-1:0] rdy, input logic ov,
                          input logic [W-1:0] od, input logic [2:0] os, input logic ol);
      check($sformatf("dut%0d_req_ready", d), rdy, exp_ready(d));
      check($sformatf("dut%0d_out_valid", d), ov, m_valid[d]);
      check($sformatf("dut%0d_out_data", d), od, m_data[d]);
      check($sformatf("dut%0d_out_src", d), os, m_src[d]);
      check($sformatf("dut%0d_out_last", d), ol, m_last[d]);
   endtask

   always @(negedge clk) begin
      cmp_dut(0, bif0.req_ready, bif0.out_valid, bif0.out_data, bif0.out_src, bif0.out_last);
      cmp_dut(1, bif1.req_ready, bif1.out_valid, bif1.out_data, bif1.out_src, bif1.out_last);
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      req_valid = '0;
      rst = 1'b0;
      tick();
      rst = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < N; i++) req_data[i] = W'(1000 * i);
      tick();
      tick();
      rst = 1'b1;
      tick();

      // Single channel
      req_valid = 8'h08;
      #1;
      check("t1_ready_rr", bif0.req_ready, 8'h08);
      check("t1_ready_fx", bif1.req_ready, 8'h08);
      tick();
      req_valid = '0;
      check("t1_valid", bif0.out_valid, 1);
      check("t1_data", bif0.out_data, 3000);
      check("t1_src", bif0.out_src, 3);
      check("t1_src_fx", bif1.out_src, 3);
      tick();

      // Round-robin fairness from ptr=0
      do_reset();
      req_valid = 8'hFF;
      for (int i = 0; i < 9; i++) begin
         tick();
         check($sformatf("t2_src%0d", i), bif0.out_src, i % 8);
         check($sformatf("t2_data%0d", i), bif0.out_data, 1000 * (i % 8));
      end
      req_valid = '0;
      tick();

      // Fixed priority
      req_valid = 8'hA4;
      for (int i = 0; i < 4; i++) begin
         tick();
         check($sformatf("t3_src%0d", i), bif1.out_src, 2);
         check($sformatf("t3_data%0d", i), bif1.out_data, 2000);
      end
      req_valid = '0;
      tick();

      // Backpressure
      do_reset();
      req_valid = 8'h60;
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check($sformatf("t4_src%0d", i), bif0.out_src, 5);
         check($sformatf("t4_data%0d", i), bif0.out_data, 5000);
         check($sformatf("t4_ready%0d", i), bif0.req_ready, 0);
      end
      out_ready = 1'b1;
      #1;
      check("t4_ready_release", bif0.req_ready, 8'h40);
      tick();
      req_valid = '0;
      check("t4_src_next", bif0.out_src, 6);
      tick();
      check("t4_drain", bif0.out_valid, 0);

      // Burst lock on channel 1 with channel 4 waiting, chan_en dropped mid-burst
      do_reset();
      req_valid = 8'h12;
      req_last  = 8'hFD;
      tick();
      check("t5_beat1_src", bif0.out_src, 1);
      check("t5_beat1_last", bif0.out_last, 0);
      chan_en = 8'hFD;
      tick();
      check("t5_beat2_src", bif0.out_src, 1);
      chan_en  = 8'hFF;
      req_last = 8'hFF;
      tick();
      check("t5_beat3_src", bif0.out_src, 1);
      check("t5_beat3_last", bif0.out_last, 1);
      check("t5_model_ptr", m_ptr[0], 2);
      tick();
      check("t5_after_src", bif0.out_src, 4);
      check("t5_after_data", bif0.out_data, 4000);

      // Reset in the middle of a locked burst
      req_valid = 8'h02;
      req_last  = 8'hFD;
      tick();
      check("t6_locked_src", bif0.out_src, 1);
      check("t6_locked_valid", bif0.out_valid, 1);
      rst = 1'b0;
      #1;
      check("t6_async_valid", bif0.out_valid, 0);
      check("t6_async_ready", bif0.req_ready, 0);
      tick();
      rst       = 1'b1;
      req_last  = 8'hFF;
      req_valid = 8'h10;
      #1;
      check("t6_ready_after", bif0.req_ready, 8'h10);
      tick();
      check("t6_src_after", bif0.out_src, 4);
      check("t6_valid_after", bif0.out_valid, 1);

      // Randomised traffic, checked every cycle against the model
      for (int n = 0; n < 3000; n++) begin
         chan_en   = N'($urandom | $urandom);
         req_valid = N'($urandom);
         req_last  = N'($urandom | $urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         rst       = ($urandom_range(0, 299) != 0);
         for (int i = 0; i < N; i++) req_data[i] = $urandom;
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
